// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction boot loader
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, W_HI, W_LO, WRITE, DONE, ERR
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    localparam logic [3:0] WMASK_LO = 4'b0011;
    localparam logic [3:0] WMASK_HI = 4'b1100;
    localparam int BANK_W = 3;
    localparam int ROW_W  = 9;

    // One-cold bank select; csb is indexed [0:7] so csb[bank] is the bank's strobe.
    function automatic logic [0:7] bank_csb(input logic [BANK_W-1:0] bank);
        logic [0:7] c;
        c = 8'hFF;
        c[bank] = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - instruction SRAM write port driven by the loader
interface instr_loader_if;
    logic [0:7]  instr_mem_csb;
    logic        instrw_enb;
    logic [3:0]  instr_wmask;
    logic [8:0]  instr_mem_addr_9bit;
    logic [15:0] instr_write_data;

    modport master (
        output instr_mem_csb, instrw_enb, instr_wmask, instr_mem_addr_9bit, instr_write_data
    );
    modport slave (
        input instr_mem_csb, instrw_enb, instr_wmask, instr_mem_addr_9bit, instr_write_data
    );
endinterface

// File: rtl/instr_loader_uart_rx.sv
// rtl/instr_loader_uart_rx.sv - 8N1 UART byte receiver with start-bit glitch rejection
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_prev_q;
    logic             valid_d, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync) state_d = RX_START;
            end
            RX_START: begin
                // Mid-start-bit recheck: a line that is high again was only a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync;
                    ferr_d  = !rx_sync;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_prev_q  <= 1'b1;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_prev_q  <= rx_sync;
            byte_valid <= valid_d;
            frame_err  <= ferr_d;
            if (valid_d) byte_data <= shift_q;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - UART boot loader writing 16-bit instructions into the SRAM banks
module instr_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 8192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  load_en,
    instr_loader_if.master        mem,
    output logic                  loading,
    output logic                  start,
    output logic                  load_err
);

    logic        rx_meta_q, rx_sync_q;
    logic        byte_valid, frame_err;
    logic [7:0]  byte_data;

    load_state_t state_q, state_d;
    logic [7:0]  n_hi_q, w_hi_q;
    logic [15:0] n_q;
    logic [13:0] a_q;
    logic [13:0] a_inc;
    logic [15:0] n_word;
    logic        load_err_q;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_sync    (rx_sync_q),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign a_inc  = a_q + 14'd1;
    assign n_word = {n_hi_q, byte_data};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (load_en) state_d = CNT_HI;
            CNT_HI: if (byte_valid) state_d = CNT_LO;
            CNT_LO: begin
                if (byte_valid) begin
                    if (n_word == 16'd0)
                        state_d = DONE;
                    else if ({16'd0, n_word} > 32'(MAX_WORDS))
                        state_d = ERR;
                    else
                        state_d = W_HI;
                end
            end
            W_HI:   if (byte_valid) state_d = W_LO;
            W_LO:   if (byte_valid) state_d = WRITE;
            WRITE:  state_d = ({2'b00, a_inc} == n_q) ? DONE : W_HI;
            DONE:   state_d = IDLE;
            ERR:    state_d = ERR;
            default: state_d = ERR;
        endcase
        if (frame_err && state_q != IDLE) state_d = ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q               <= 1'b1;
            rx_sync_q               <= 1'b1;
            state_q                 <= IDLE;
            n_hi_q                  <= '0;
            w_hi_q                  <= '0;
            n_q                     <= '0;
            a_q                     <= '0;
            load_err_q              <= 1'b0;
            mem.instr_mem_csb       <= 8'hFF;
            mem.instrw_enb          <= 1'b1;
            mem.instr_wmask         <= '0;
            mem.instr_mem_addr_9bit <= '0;
            mem.instr_write_data    <= '0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            state_q    <= state_d;
            load_err_q <= load_err_q | (state_d == ERR);
            if (state_q == CNT_HI && byte_valid) n_hi_q <= byte_data;
            if (state_q == CNT_LO && byte_valid) begin
                n_q <= n_word;
                a_q <= '0;
            end
            if (state_q == W_HI && byte_valid) w_hi_q <= byte_data;
            if (state_q == WRITE) a_q <= a_inc;
            // Strobes are registered on entry to WRITE so they are stable for exactly that cycle.
            if (state_d == WRITE) begin
                mem.instr_mem_csb       <= bank_csb(a_q[12:10]);
                mem.instrw_enb          <= 1'b0;
                mem.instr_wmask         <= a_q[0] ? WMASK_HI : WMASK_LO;
                mem.instr_mem_addr_9bit <= a_q[ROW_W:1];
                mem.instr_write_data    <= {w_hi_q, byte_data};
            end else begin
                mem.instr_mem_csb       <= 8'hFF;
                mem.instrw_enb          <= 1'b1;
            end
        end
    end

    assign loading  = (state_q == W_HI) || (state_q == W_LO) || (state_q == WRITE);
    assign start    = (state_q == DONE);
    assign load_err = load_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - scoreboard bench for instr_loader
module tb_instr_loader;
    import loader_pkg::*;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic load_en = 1'b0;
    logic loading, start, load_err;

    instr_loader_if mif();

    instr_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(8192)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .load_en  (load_en),
        .mem      (mif),
        .loading  (loading),
        .start    (start),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:7]  csb;
        logic [3:0]  wmask;
        logic [8:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_wr_q[$];
    bit  exp_start_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  last_wr_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic wr_t exp_of(input int a, input logic [15:0] d);
        wr_t w;
        logic [0:7] c;
        c = 8'hFF;
        c[a[12:10]] = 1'b0;
        w.csb   = c;
        w.wmask = a[0] ? 4'b1100 : 4'b0011;
        w.addr  = a[9:1];
        w.data  = d;
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        bit  need_wr;
        if (!reset) begin
            check("web_matches_csb", {31'd0, mif.instrw_enb}, {31'd0, mif.instr_mem_csb == 8'hFF});
            if (mif.instr_mem_csb != 8'hFF) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write_csb", {24'd0, mif.instr_mem_csb}, 32'hFF);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("wr_csb",   {24'd0, mif.instr_mem_csb}, {24'd0, e.csb});
                    check("wr_wmask", {28'd0, mif.instr_wmask}, {28'd0, e.wmask});
                    check("wr_addr",  {23'd0, mif.instr_mem_addr_9bit}, {23'd0, e.addr});
                    check("wr_data",  {16'd0, mif.instr_write_data}, {16'd0, e.data});
                end
                last_wr_cyc = cyc;
            end
            if (start) begin
                if (exp_start_q.size() == 0) begin
                    check("unexpected_start", {31'd0, start}, 32'd0);
                end else begin
                    need_wr = exp_start_q.pop_front();
                    if (need_wr) check("start_after_last_write", cyc - last_wr_cyc, 32'd1);
                    check("loading_low_at_start", {31'd0, loading}, 32'd0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop) repeat (CPB) @(negedge clk);
    endtask

    task automatic arm();
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic settle_and_drain(input string tag);
        repeat (40) @(negedge clk);
        check({tag, "_writes_drained"}, exp_wr_q.size(), 32'd0);
        check({tag, "_starts_drained"}, exp_start_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_csb",      {24'd0, mif.instr_mem_csb}, 32'hFF);
        check("rst_web",      {31'd0, mif.instrw_enb}, 32'd1);
        check("rst_wmask",    {28'd0, mif.instr_wmask}, 32'd0);
        check("rst_addr",     {23'd0, mif.instr_mem_addr_9bit}, 32'd0);
        check("rst_data",     {16'd0, mif.instr_write_data}, 32'd0);
        check("rst_loading",  {31'd0, loading}, 32'd0);
        check("rst_start",    {31'd0, start}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #980000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Two half-words into bank 0, row 0.
        arm();
        exp_wr_q.push_back({8'b01111111, 4'b0011, 9'd0, 16'h1234});
        exp_wr_q.push_back({8'b01111111, 4'b1100, 9'd0, 16'hABCD});
        exp_start_q.push_back(1'b1);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        check("loading_mid_load", {31'd0, loading}, 32'd1);
        send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        settle_and_drain("two_words");
        check("loading_after_done", {31'd0, loading}, 32'd0);

        // Empty program: start without writes.
        arm();
        exp_start_q.push_back(1'b0);
        send_byte(8'h00); send_byte(8'h00);
        settle_and_drain("n_zero");

        // Bank crossing: word 1024 is the first write to bank 1.
        arm();
        send_byte(8'h04); send_byte(8'h02);
        for (int i = 0; i < 1026; i++) begin
            if (i == 1024)
                exp_wr_q.push_back({8'b10111111, 4'b0011, 9'd0, 16'h0400});
            else
                exp_wr_q.push_back(exp_of(i, i[15:0]));
            if (i == 1025) exp_start_q.push_back(1'b1);
            send_byte(i[15:8]);
            send_byte(i[7:0]);
        end
        settle_and_drain("bank_cross");

        // Reset between the bytes of word 5, then a fresh load from address 0.
        arm();
        send_byte(8'h00); send_byte(8'h08);
        for (int i = 0; i < 5; i++) begin
            exp_wr_q.push_back(exp_of(i, 16'hC000 | i[15:0]));
            send_byte(8'hC0);
            send_byte(i[7:0]);
        end
        send_byte(8'hC0);
        repeat (4) @(negedge clk);
        do_reset();
        settle_and_drain("abort");
        arm();
        exp_wr_q.push_back({8'b01111111, 4'b0011, 9'd0, 16'h55AA});
        exp_start_q.push_back(1'b1);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h55); send_byte(8'hAA);
        settle_and_drain("after_abort");

        // Oversized word count goes to ERR with no writes.
        arm();
        send_byte(8'h20); send_byte(8'h01);
        settle_and_drain("too_big");
        check("too_big_load_err", {31'd0, load_err}, 32'd1);
        check("too_big_loading",  {31'd0, loading}, 32'd0);
        do_reset();

        // Bad stop bit on the third byte; later stream ignored until reset.
        arm();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12, 1'b0);
        settle_and_drain("frame_err");
        check("frame_err_load_err", {31'd0, load_err}, 32'd1);
        arm();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        settle_and_drain("ignored_after_err");
        check("sticky_load_err", {31'd0, load_err}, 32'd1);
        check("err_loading",     {31'd0, loading}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
